// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional LEADING_ZERO_BLANK_EN adds a registered leading-zero blanking mask (blank_o).
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_o
`endif
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic             last;
  // Digits are adjusted independently; a digit's +3 never carries into its neighbour.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3 : scratch_q[4*k +: 4];
  end
  assign shifted = {adj[BW-2:0], shift_q[BIN_W-1]};
  assign last    = cnt_q == CW'(BIN_W - 1);
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        state_d   = S_CONV;
        shift_d   = bin_i;
        scratch_d = '0;
        cnt_d     = '0;
        sticky_d  = 1'b0;
      end
    end else if (state_q == S_CONV) begin
      scratch_d = shifted;
      shift_d   = shift_q << 1;
      sticky_d  = sticky_q | adj[BW-1];
      cnt_d     = cnt_q + CW'(1);
      if (last) begin
        state_d = S_DONE;
        bcd_d   = shifted;
        ovf_d   = sticky_q | adj[BW-1];
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end
  assign ready_o    = state_q == S_IDLE;
  assign done_o     = state_q == S_DONE;
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_n;
  logic              zero_run;
  // Digit 0 is never blanked so a zero result still shows one "0".
  always_comb begin
    blank_n  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (shifted[4*k +: 4] == 4'd0);
      blank_n[k] = zero_run;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank_q <= ~DIGITS'(1);
    else if (state_q == S_CONV && last)
      blank_q <= blank_n;
  end
  assign blank_o = blank_q;
`endif
endmodule
